// File: rtl/mips_datapath_immediate_extend_pkg.sv
// Shared immediate-control encodings and helpers for the immediate extend datapath.
// Both pipeline stages and the arithmetic between them use these types.
package mips_datapath_immediate_extend_pkg;

  typedef enum logic {
    EXTEND_UNSIGNED = 1'b0,
    EXTEND_SIGNED   = 1'b1
  } extend_e;

  typedef enum logic {
    SHIFT_NONE   = 1'b0,
    SHIFT_LEFT16 = 1'b1
  } shift_e;

  typedef struct packed {
    extend_e extend;
    shift_e  shift;
  } mips_control_signal_immediate_control_t;

  localparam mips_control_signal_immediate_control_t INIT_DEFAULTS = '{
    extend: EXTEND_UNSIGNED,
    shift:  SHIFT_NONE
  };

  // Stage A payload: the extended value plus the shift still to be applied.
  typedef struct packed {
    logic [31:0] ext;
    shift_e      shift;
  } stage_a_t;

  function automatic logic [31:0] extend_immediate(input logic [15:0] imm, input extend_e extend);
    logic [15:0] upper;
    upper = (extend == EXTEND_SIGNED) ? {16{imm[15]}} : 16'h0000;
    return {upper, imm};
  endfunction

  // Left16 only needs the raw immediate, which is the low half of the extended value.
  function automatic logic [31:0] apply_shift(input logic [31:0] ext, input shift_e shift);
    return (shift == SHIFT_LEFT16) ? {ext[15:0], 16'h0000} : ext;
  endfunction

endpackage

// File: rtl/mips_datapath_immediate_extend_stage.sv
// Single valid/data pipeline slice with load and clear.
// Reset clears valid and data; clear only drops valid.
module mips_datapath_immediate_extend_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= valid_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/mips_datapath_immediate_extend.sv
// Two-stage elastic pipeline: stage A holds the extended immediate and pending shift,
// stage B holds the final 32-bit result presented downstream.
module mips_datapath_immediate_extend
  import mips_datapath_immediate_extend_pkg::*;
(
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [15:0]                            immediate,
  input  mips_control_signal_immediate_control_t control,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [31:0]                            out_value,
  output logic [1:0]                             occupancy
);

  stage_a_t    a_d;
  stage_a_t    a_q;
  logic        valid_a;
  logic        valid_b;
  logic        b_load;
  logic        a_moves;
  logic [31:0] b_d;

  // B accepts from A whenever it is empty or draining this cycle.
  assign b_load  = !valid_b || out_ready;
  assign a_moves = valid_a && b_load;
  assign in_ready = !reset && !flush && (!valid_a || a_moves);

  assign a_d = '{ext: extend_immediate(immediate, control.extend), shift: control.shift};
  assign b_d = apply_shift(a_q.ext, a_q.shift);

  mips_datapath_immediate_extend_stage #(
    .WIDTH($bits(stage_a_t))
  ) u_stage_a (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .load    (in_ready),
    .valid_d (in_valid),
    .data_d  (a_d),
    .valid   (valid_a),
    .data    (a_q)
  );

  mips_datapath_immediate_extend_stage #(
    .WIDTH(32)
  ) u_stage_b (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .load    (b_load),
    .valid_d (valid_a),
    .data_d  (b_d),
    .valid   (valid_b),
    .data    (out_value)
  );

  assign out_valid = valid_b;
  assign occupancy = {1'b0, valid_a} + {1'b0, valid_b};

endmodule

// File: tb/tb_mips_datapath_immediate_extend.sv
// Directed-vector bench for the immediate extend pipeline.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
module tb_mips_datapath_immediate_extend;
  import mips_datapath_immediate_extend_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] immediate;
  mips_control_signal_immediate_control_t control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic [1:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  mips_datapath_immediate_extend dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immediate (immediate),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .occupancy (occupancy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    immediate = 16'h5555; control = INIT_DEFAULTS;
    tick(); tick();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++;
    if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    vectors++;
    if (out_value !== 32'h0) begin miscompares++; $display("FAIL reset_out_value got=%h exp=00000000", out_value); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_extend();
    logic [15:0] imm_tab [7] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h1234, 16'h1234, 16'h8001, 16'hFFFF};
    logic        ext_tab [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        sh_tab  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_tab [7] = '{32'h00008000, 32'hFFFF8000, 32'h00007FFF, 32'h12340000,
                                 32'h12340000, 32'h80010000, 32'h0000FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      immediate = imm_tab[i];
      control.extend = extend_e'(ext_tab[i]);
      control.shift  = shift_e'(sh_tab[i]);
      in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL extend_in_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      in_valid = 1'b0; immediate = 16'h0000;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL extend_early_valid[%0d] got=%b exp=0", i, out_valid); end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_value !== exp_tab[i]) begin
        miscompares++;
        $display("FAIL extend_value[%0d] got valid=%b value=%h exp valid=1 value=%h", i, out_valid, out_value, exp_tab[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    control = INIT_DEFAULTS; out_ready = 1'b0;
    in_valid = 1'b1; immediate = 16'd1; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept1 got=%b exp=1", in_ready); end
    tick();
    immediate = 16'd2; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_accept2 got=%b exp=1", in_ready); end
    tick();
    immediate = 16'd3;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_valid !== 1'b1 || out_value !== 32'd1) begin
        miscompares++;
        $display("FAIL b2b_full[%0d] got rdy=%b occ=%0d vld=%b val=%h exp rdy=0 occ=2 vld=1 val=00000001",
                 c, in_ready, occupancy, out_valid, out_value);
      end
      tick();
    end
    out_ready = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b1 || out_value !== 32'd1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_release got rdy=%b vld=%b val=%h exp rdy=1 vld=1 val=00000001", in_ready, out_valid, out_value);
    end
    tick();
    in_valid = 1'b0; #1;
    vectors++;
    if (out_valid !== 1'b1 || out_value !== 32'd2 || occupancy !== 2'd2) begin
      miscompares++;
      $display("FAIL b2b_second got vld=%b val=%h occ=%0d exp vld=1 val=00000002 occ=2", out_valid, out_value, occupancy);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_value !== 32'd3 || occupancy !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_third got vld=%b val=%h occ=%0d exp vld=1 val=00000003 occ=1", out_valid, out_value, occupancy);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_drained got vld=%b occ=%0d exp vld=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic fill_two();
    control = INIT_DEFAULTS; out_ready = 1'b0; in_valid = 1'b1;
    immediate = 16'h0011; tick();
    immediate = 16'h0022; tick();
    in_valid = 1'b0; #1;
    vectors++;
    if (occupancy !== 2'd2) begin miscompares++; $display("FAIL fill_occupancy got=%0d exp=2", occupancy); end
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1; in_valid = 1'b1; immediate = 16'h0033; #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_cleared got vld=%b occ=%0d exp vld=0 occ=0", out_valid, occupancy);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stale[%0d] got vld=%b exp=0", c, out_valid); end
    end
    control.extend = EXTEND_SIGNED; control.shift = SHIFT_NONE;
    in_valid = 1'b1; immediate = 16'h0044; tick();
    in_valid = 1'b0; tick();
    vectors++;
    if (out_valid !== 1'b1 || out_value !== 32'h00000044) begin
      miscompares++;
      $display("FAIL flush_next_item got vld=%b val=%h exp vld=1 val=00000044", out_valid, out_value);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    fill_two();
    reset = 1'b1; in_valid = 1'b1; immediate = 16'h0099; tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_value !== 32'h0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got vld=%b occ=%0d val=%h rdy=%b exp vld=0 occ=0 val=00000000 rdy=0",
               out_valid, occupancy, out_value, in_ready);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mid_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_stale[%0d] got vld=%b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_extend();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_datapath_immediate_extend.md
MIPS_DATAPATH_IMMEDIATE_EXTEND -- requirements
Module: Mips_Datapath_Immediate_extend

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 flush  input  1  synchronous pipeline kill; discards all in-flight items.
REQ-004 in_valid  input  1  upstream offers one item this cycle.
REQ-005 in_ready  output  1  block accepts the offered item this cycle.
REQ-006 immediate  input  16  raw instruction immediate field.
REQ-007 control  input  Mips_Control_Signal_Immediate_Control_T  extend field (Signed/Unsigned) and shift field (None/Left16).
REQ-008 out_valid  output  1  out_value holds a completed item.
REQ-009 out_ready  input  1  downstream consumes the item this cycle.
REQ-010 out_value  output  32  extended and shifted immediate.
REQ-011 occupancy  output  2  number of valid items held, 0..2.

Function
REQ-012 Transfers occur only on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-013 Stage A registers the extended value and the shift field; stage B registers the final 32-bit result.
REQ-014 Extend Signed: bits[31:16] = immediate[15]. Extend Unsigned: bits[31:16] = 0.
REQ-015 Shift Left16: result = {immediate, 16'h0}, independent of extend; shift None: result = extended value.
REQ-016 Latency: an item accepted in cycle N has out_valid=1 in cycle N+2 when no stall occurs.
REQ-017 Stage B loads from A when B is empty or is being consumed this cycle.
REQ-018 Stage A loads from input when A is empty or is moving to B this cycle.
REQ-019 in_ready = !validA || (A moves to B this cycle); combinational, and depends on out_ready only through this rule.
REQ-020 Throughput is one item per cycle while out_ready=1.
REQ-021 Items leave in acceptance order; none are dropped or duplicated.
REQ-022 Full (both valid, out_ready=0): in_ready=0, all registers hold.
REQ-023 Empty: out_valid=0, occupancy=0, in_ready=1.
REQ-024 Simultaneous accept and consume with both stages full: A moves to B and the input enters A; occupancy stays 2.
REQ-025 occupancy = validA + validB, registered.
REQ-026 flush=1: both valids clear next cycle; in_ready=0 during the flush cycle; an input offered in that cycle is not accepted; flush has priority over every transfer.
REQ-027 out_value is held stable while out_valid=1 and out_ready=0.

Reset
REQ-028 reset has priority over flush and every transfer.
REQ-029 After reset: validA=validB=0, out_valid=0, occupancy=0, out_value=32'h0, stage A data=0.
REQ-030 in_ready=0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-031 Reset mid-operation discards all in-flight items; no stale item appears after reset.

Structure
REQ-032 The extend and shift encodings, the Control_T field macros and the Init_Defaults constant come from the shared Mips/Control/Signal/Immediate/Control.v package; this block defines no local copies.
REQ-033 One sub-module, Mips_Datapath_Immediate_stage: a single valid/data register slice with load and clear. The block instantiates it twice, once for A and once for B.
REQ-034 The arithmetic is combinational logic between the slices and contains no state.

Verification
REQ-035 Unsigned, None, immediate 16'h8000, out_ready=1 -> out_value 32'h00008000, two cycles after acceptance.
REQ-036 Signed, None, immediate 16'h8000 -> 32'hFFFF8000; Signed, None, 16'h7FFF -> 32'h00007FFF.
REQ-037 Left16, either extend, immediate 16'h1234 -> 32'h12340000.
REQ-038 Three back-to-back items (1, 2, 3), out_ready=0 for 4 cycles -> in_ready drops after two items are accepted and occupancy=2. On release, outputs appear as 1, 2, 3 in consecutive cycles.
REQ-039 Flush with occupancy=2 and an input offered -> out_valid=0 and occupancy=0 next cycle; the offered input is not accepted; the next accepted item emerges correctly.
REQ-040 Reset asserted with occupancy=2 -> all outputs reach their REQ-029 values next cycle, and in_ready=1 one cycle after reset deasserts.
